// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the RTC read path.
//   - rtc_state_e : bus-cycle / burst states
//   - NUM_REGS    : number of RTC registers read per burst
//   - RTC_RD_ADDR : RTC register address for each burst index
//   - bus_ctl_t   : bus strobe bundle, with one constant per phase
package rtc_pkg;

    localparam int NUM_REGS = 9;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_REL = 3'd2,
        ST_DATA     = 3'd3,
        ST_DATA_REL = 3'd4,
        ST_UPDATE   = 3'd5
    } rtc_state_e;

    // Clock/date block first, then the timer block.
    localparam logic [7:0] RTC_RD_ADDR [0:NUM_REGS-1] = '{
        8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43
    };

    typedef struct packed {
        logic cs_n;
        logic rd_n;
        logic wr_n;
        logic a_d;
        logic oe;
    } bus_ctl_t;

    localparam bus_ctl_t BUS_IDLE     = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, a_d: 1'b0, oe: 1'b0};
    localparam bus_ctl_t BUS_ADDR     = '{cs_n: 1'b0, rd_n: 1'b1, wr_n: 1'b0, a_d: 1'b0, oe: 1'b1};
    localparam bus_ctl_t BUS_ADDR_REL = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, a_d: 1'b0, oe: 1'b1};
    localparam bus_ctl_t BUS_DATA     = '{cs_n: 1'b0, rd_n: 1'b0, wr_n: 1'b1, a_d: 1'b1, oe: 1'b0};

    // DATA_REL drives the same levels as idle: every strobe released.
    function automatic bus_ctl_t bus_ctl(input rtc_state_e st);
        case (st)
            ST_ADDR:     return BUS_ADDR;
            ST_ADDR_REL: return BUS_ADDR_REL;
            ST_DATA:     return BUS_DATA;
            default:     return BUS_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rtc_bus_ciclo.sv
// rtc_bus_ciclo: sequences one RTC read access (ADDR, ADDR_REL, DATA, DATA_REL),
// each phase lasting T_PH cycles. All bus outputs are registered.
//   go/addr   : request an access; sampled while idle or on the last access cycle
//   ad_in     : bus data from the RTC
//   ad_out/ad_oe/cs_n/rd_n/wr_n/a_d : registered bus drive
//   busy      : an access is in progress (registered)
//   rdata/ack : read byte, valid while ack is high (last DATA cycle)
//   fin       : last cycle of the access; a new go here chains without a gap
module rtc_bus_ciclo
    import rtc_pkg::*;
#(
    parameter int T_PH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [7:0] addr,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic       busy,
    output logic [7:0] rdata,
    output logic       ack,
    output logic       fin
);

    localparam int PW = (T_PH > 1) ? $clog2(T_PH) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(T_PH - 1);

    rtc_state_e    phase_q, phase_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [7:0]    ad_out_q, ad_out_d;
    bus_ctl_t      ctl_q, ctl_d;
    logic          busy_q, busy_d;
    logic          ph_end;

    assign ph_end = (cnt_q == PH_LAST);
    assign ack    = (phase_q == ST_DATA) && ph_end;
    assign fin    = (phase_q == ST_DATA_REL) && ph_end;
    assign rdata  = ad_in;

    always_comb begin
        // NOTE: every variable gets a default first so no path through this block infers a latch.
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        ad_out_d = ad_out_q;
        if (go && (phase_q == ST_IDLE || fin)) begin
            phase_d  = ST_ADDR;
            cnt_d    = '0;
            ad_out_d = addr;
        end else if (phase_q != ST_IDLE) begin
            if (ph_end) begin
                cnt_d = '0;
                case (phase_q)
                    ST_ADDR:     phase_d = ST_ADDR_REL;
                    ST_ADDR_REL: phase_d = ST_DATA;
                    ST_DATA:     phase_d = ST_DATA_REL;
                    default:     phase_d = ST_IDLE;
                endcase
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Strobes are decoded from the next phase so they leave flops aligned with it.
        ctl_d  = bus_ctl(phase_d);
        busy_d = (phase_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q  <= ST_IDLE;
            cnt_q    <= '0;
            ad_out_q <= '0;
            ctl_q    <= BUS_IDLE;
            busy_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            ad_out_q <= ad_out_d;
            ctl_q    <= ctl_d;
            busy_q   <= busy_d;
        end
    end

    assign ad_out = ad_out_q;
    assign ad_oe  = ctl_q.oe;
    assign cs_n   = ctl_q.cs_n;
    assign rd_n   = ctl_q.rd_n;
    assign wr_n   = ctl_q.wr_n;
    assign a_d    = ctl_q.a_d;
    assign busy   = busy_q;

endmodule

// File: rtl/rtc_lectura.sv
// rtc_lectura: reads the nine RTC time/date/timer registers in one burst and
// publishes them atomically as 8-bit BCD fields.
//   start : one-cycle read request     hold : suspends/aborts bursts (user editing)
//   ad_in / ad_out / ad_oe / cs_n / rd_n / wr_n / a_d : RTC multiplexed bus
//   busy  : burst in progress          done : one-cycle pulse, fields just updated
//   seg_C..hora_T : BCD fields, raw RTC bytes
// The UPDATE state is the cycle in which done_q is high; the bus sequencer is idle then,
// so a queued request can start the next burst from it directly.
module rtc_lectura
    import rtc_pkg::*;
#(
    parameter int T_PH        = 4,
    parameter int AUTO_PERIOD = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hold,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic       busy,
    output logic       done,
    output logic [7:0] seg_C,
    output logic [7:0] min_C,
    output logic [7:0] hora_C,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] ano,
    output logic [7:0] seg_T,
    output logic [7:0] min_T,
    output logic [7:0] hora_T
);

    localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);
    localparam logic [3:0]    LAST_IDX  = 4'(NUM_REGS - 1);

    logic [AW-1:0] auto_cnt_q, auto_cnt_d;
    logic          auto_hit;
    logic          pending_q, pending_d;
    logic          abort_q, abort_d;
    logic          done_q, done_d;
    logic [3:0]    k_q, k_d;
    logic [7:0]    shadow_q [0:NUM_REGS-1];
    logic [7:0]    shadow_d [0:NUM_REGS-1];
    logic [7:0]    field_q  [0:NUM_REGS-1];
    logic [7:0]    field_d  [0:NUM_REGS-1];

    logic       go;
    logic [7:0] go_addr;
    logic       bus_busy;
    logic [7:0] rdata;
    logic       ack;
    logic       fin;

    // Free-running request timer; independent of the burst state.
    always_comb begin
        auto_hit   = 1'b0;
        auto_cnt_d = '0;
        if (AUTO_PERIOD != 0) begin
            auto_hit   = (auto_cnt_q == AUTO_LAST);
            auto_cnt_d = auto_hit ? '0 : auto_cnt_q + 1'b1;
        end
    end

    always_comb begin
        pending_d = pending_q | start | auto_hit;
        abort_d   = abort_q;
        done_d    = 1'b0;
        k_d       = k_q;
        go        = 1'b0;
        field_d   = field_q;
        shadow_d  = shadow_q;

        if (ack) shadow_d[k_q] = rdata;

        if (!bus_busy) begin
            // Same-cycle requests count, so a start in cycle 0 drives ADDR in cycle 1.
            abort_d = 1'b0;
            if ((pending_q || start || auto_hit) && !hold) begin
                go        = 1'b1;
                k_d       = '0;
                pending_d = 1'b0;
            end
        end else begin
            // Remember hold even if it drops before the access finishes.
            if (hold) abort_d = 1'b1;
            if (fin) begin
                abort_d = 1'b0;
                if (abort_q || hold) begin
                    pending_d = 1'b1;
                end else if (k_q != LAST_IDX) begin
                    go  = 1'b1;
                    k_d = k_q + 4'd1;
                end else begin
                    done_d  = 1'b1;
                    field_d = shadow_q;
                end
            end
        end
    end

    assign go_addr = RTC_RD_ADDR[k_d];

    rtc_bus_ciclo #(
        .T_PH (T_PH)
    ) u_bus (
        .clk    (clk),
        .reset  (reset),
        .go     (go),
        .addr   (go_addr),
        .ad_in  (ad_in),
        .ad_out (ad_out),
        .ad_oe  (ad_oe),
        .cs_n   (cs_n),
        .rd_n   (rd_n),
        .wr_n   (wr_n),
        .a_d    (a_d),
        .busy   (bus_busy),
        .rdata  (rdata),
        .ack    (ack),
        .fin    (fin)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            auto_cnt_q <= '0;
            pending_q  <= 1'b0;
            abort_q    <= 1'b0;
            done_q     <= 1'b0;
            k_q        <= '0;
            field_q    <= '{default: '0};
        end else begin
            auto_cnt_q <= auto_cnt_d;
            pending_q  <= pending_d;
            abort_q    <= abort_d;
            done_q     <= done_d;
            k_q        <= k_d;
            field_q    <= field_d;
        end
    end

    // NOTE: shadows carry no reset; every entry is rewritten before it can reach the fields.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    assign busy   = bus_busy;
    assign done   = done_q;
    assign seg_C  = field_q[0];
    assign min_C  = field_q[1];
    assign hora_C = field_q[2];
    assign dia    = field_q[3];
    assign mes    = field_q[4];
    assign ano    = field_q[5];
    assign seg_T  = field_q[6];
    assign min_T  = field_q[7];
    assign hora_T = field_q[8];

endmodule

// File: doc/rtc_lectura.md
# rtc_lectura

Periodic/on-demand reader that pulls current time, date and timer values out of the external RTC over its multiplexed address/data bus. It presents them as 8-bit BCD fields to the display path and sits alongside the user data-entry block. All nine fields are read in one burst and updated atomically, so the display never shows a half-updated time. While the user is editing values, `hold` suspends reads.

## Interface
Parameters:
- `T_PH`, 4: cycles per bus phase (≥1).
- `AUTO_PERIOD`, 1000000: cycles between automatic read requests; 0 disables auto-read.

Ports (reset reset, asynchronous, active-high; clock clk):
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  one-cycle read request
- `hold`  in  1  level; suppresses/aborts bursts (user editing)
- `ad_in`  in  8  bus data from RTC
- `ad_out`  out  8  address driven to bus
- `ad_oe`  out  1  tristate enable for `ad_out`
- `cs_n`, `rd_n`, `wr_n`  out  1 each  active-low bus strobes
- `a_d`  out  1  0 = address phase, 1 = data phase
- `busy`  out  1  burst in progress
- `done`  out  1  one-cycle pulse; fields just updated
- `seg_C`, `min_C`, `hora_C`, `dia`, `mes`, `ano`, `seg_T`, `min_T`, `hora_T`  out  8 each  BCD fields

## Operation
- `pending` flag is set by `start`, or by the auto counter reaching `AUTO_PERIOD-1`. The counter then wraps to 0. It runs freely, independent of state.
- A burst starts when the FSM is in IDLE, `pending` = 1 and `hold` = 0. Starting a burst clears `pending`. Requests that arrive while busy set `pending` again, so the next burst follows immediately after IDLE.
- Read order, by index k = 0..8: 0x21 seg, 0x22 min, 0x23 hora, 0x24 dia, 0x25 mes, 0x26 ano, 0x41 seg_T, 0x42 min_T, 0x43 hora_T.
- Each access uses four phases, each lasting `T_PH` cycles:
  - ADDR: `cs_n`=0, `wr_n`=0, `a_d`=0, `ad_oe`=1, `ad_out`=addr.
  - ADDR_REL: `wr_n`=1, `ad_oe`=1, `cs_n`=1.
  - DATA: `cs_n`=0, `rd_n`=0, `a_d`=1, `ad_oe`=0.
  - DATA_REL: all strobes = 1, `a_d`=0.
- `ad_in` is captured into shadow[k] on the last DATA cycle.
- FSM: IDLE → ADDR → ADDR_REL → DATA → DATA_REL. From DATA_REL it goes to ADDR with k+1 when k<8, or to UPDATE when k=8. UPDATE copies all shadows to the outputs, pulses `done` and returns to IDLE.
- `hold` rising mid-burst: the current access completes through DATA_REL, so the bus is never truncated. The FSM then returns to IDLE with no UPDATE and no `done`; outputs keep their old values. `pending` is set again so the burst restarts from k=0 once `hold` falls.
- `start` while `hold`=1: latched in `pending`, served after `hold` falls.
- No BCD validation; the module transports raw RTC bytes.

## Timing
- Reset values:
  - all fields 0x00, `ad_out`=0x00, `busy`=0, `done`=0
  - `ad_oe`=0, `a_d`=0
  - `cs_n`=`rd_n`=`wr_n`=1
  - `pending`=0, auto counter 0, FSM in IDLE.
- Reset mid-burst releases the bus on the next cycle, because all bus outputs are registered with async clear.
- Cycle numbering: `start` is high in cycle 0.
  - Register k ADDR occupies cycles 1+4kT … 1+4kT+T-1 (T = `T_PH`).
  - Capture of register k happens in cycle 4kT+3T.
  - UPDATE is cycle 36T+1: `done`=1 and the new fields are visible, `busy`=0.
  - `busy`=1 for cycles 1 … 36T.
- Earliest back-to-back burst: the next ADDR begins at cycle 36T+2.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `rtc_pkg`:
  - state enum (IDLE, ADDR, ADDR_REL, DATA, DATA_REL, UPDATE)
  - `NUM_REGS`=9
  - read address table `RTC_RD_ADDR[0:8]`
  - bus strobe constants
- Sub-module `rtc_bus_ciclo`: a single-access sequencer. It takes `go`/`addr` and returns `rdata`/`ack`, and contains the phase counter (width `$clog2(T_PH)`, minimum 1).
- `rtc_lectura` owns the pending/auto counter, the 4-bit index k, the shadows and the UPDATE logic.

## Test plan
- **Reset:** assert reset mid-ADDR phase → same cycle+1: `cs_n`/`rd_n`/`wr_n`=1, `ad_oe`=0, all fields 0x00.
- **Single burst:** T_PH=4; RTC model returns 0x45,0x59,0x23,0x31,0x12,0x99,0x10,0x20,0x03. Pulse `start` at cycle 0. Expect `done` only in cycle 145, with the fields equal to those values. Fields stay 0x00 through cycle 144. Address sequence on ADDR phases is 0x21…0x26, 0x41…0x43.
- **Hold abort:** raise `hold` during the DATA phase of k=3. Expect the access to finish, return to IDLE, no `done`, fields unchanged. Drop `hold` → a new burst starts at k=0 (address 0x21).
- **Queued request:** pulse `start` at cycle 50 of a burst → a second burst starts at cycle 36T+2, and `done` pulses twice.
- **Auto-read:** `AUTO_PERIOD`=200, T_PH=1, no `start` → `done` pulses every 200 cycles. With `AUTO_PERIOD`=0, no burst ever occurs.
- **Protocol check:** `ad_oe`=1 is never asserted while `rd_n`=0; `wr_n` and `rd_n` are never both 0; `cs_n` is 1 in every *_REL phase.
